// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: one load/store at a time against a word-wide,
// synchronous-read memory, with read-modify-write for byte and halfword stores.
module dm_access_ctrl #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              req,
   input  logic              we,
   input  logic [1:0]        size,
   input  logic              sext,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic              busy,
   output logic              done,
   output logic [31:0]       rdata,
   output logic              misalign,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   output logic              mem_we,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic [2:0]        fsm_state
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      WAIT  = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t      state;
   logic        we_q;
   logic        sext_q;
   logic        fault_q;
   logic [1:0]  size_q;
   logic [1:0]  lane_q;

   logic        fault;
   logic [4:0]  shamt;
   logic [31:0] shifted;
   logic [31:0] lane_mask;
   logic [31:0] merged;
   logic [31:0] load_val;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^addr[31:ADDR_W+2];

   // Reserved size 2'b11 behaves as a word, so size[1] alone selects word rules.
   assign fault = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));

   assign shamt     = {lane_q, 3'b000};
   assign shifted   = mem_rdata >> shamt;
   assign lane_mask = (size_q == 2'b00) ? (32'h0000_00ff << shamt) : (32'h0000_ffff << shamt);
   // Until the merge, mem_wdata still holds the right-aligned store data.
   assign merged    = (mem_rdata & ~lane_mask) | ((mem_wdata << shamt) & lane_mask);

   always_comb begin
      load_val = shifted;
      case (size_q)
         2'b00:   load_val = {{24{sext_q & shifted[7]}}, shifted[7:0]};
         2'b01:   load_val = {{16{sext_q & shifted[15]}}, shifted[15:0]};
         default: load_val = shifted;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         we_q      <= 1'b0;
         sext_q    <= 1'b0;
         fault_q   <= 1'b0;
         size_q    <= 2'b00;
         lane_q    <= 2'b00;
         mem_addr  <= '0;
         mem_wdata <= 32'h0;
         rdata     <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  we_q      <= we;
                  sext_q    <= sext;
                  size_q    <= size;
                  lane_q    <= addr[1:0];
                  fault_q   <= fault;
                  mem_addr  <= addr[ADDR_W+1:2];
                  mem_wdata <= wdata;
                  if (fault)
                     state <= DONE;
                  else if (we && size[1])
                     state <= WRITE;
                  else
                     state <= READ;
               end
            end
            READ: state <= WAIT;
            WAIT: begin
               if (we_q) begin
                  mem_wdata <= merged;
                  state     <= WRITE;
               end else begin
                  rdata <= load_val;
                  state <= DONE;
               end
            end
            WRITE: state <= DONE;
            DONE:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign misalign  = (state == DONE) && fault_q;
   assign mem_re    = (state == READ);
   assign mem_we    = (state == WRITE);
   assign fsm_state = state;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: synchronous memory, transaction-level timeline model
// compared every cycle, directed literal scenarios, then randomized traffic.
module tb_dm_access_ctrl;

   localparam int ADDR_W = 10;

   // ---------------- clock / reset ----------------
   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   logic              req = 1'b0;
   logic              we = 1'b0;
   logic [1:0]        size = 2'b00;
   logic              sext = 1'b0;
   logic [31:0]       addr = 32'h0;
   logic [31:0]       wdata = 32'h0;
   logic              busy;
   logic              done;
   logic [31:0]       rdata;
   logic              misalign;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_re;
   logic              mem_we;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic [2:0]        fsm_state;

   dm_access_ctrl #(.ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .req       (req),
      .we        (we),
      .size      (size),
      .sext      (sext),
      .addr      (addr),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done),
      .rdata     (rdata),
      .misalign  (misalign),
      .mem_addr  (mem_addr),
      .mem_re    (mem_re),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .fsm_state (fsm_state)
   );

   // ---------------- synchronous memory ----------------
   logic [31:0]       mem [0:(1<<ADDR_W)-1];
   logic              pre_we = 1'b0;
   logic [ADDR_W-1:0] pre_addr = '0;
   logic [31:0]       pre_data = 32'h0;

   always @(posedge clk) begin
      if (pre_we)
         mem[pre_addr] <= pre_data;
      else if (mem_we)
         mem[mem_addr] <= mem_wdata;
      if (mem_re)
         mem_rdata <= mem[mem_addr];
   end

   // ---------------- scoreboard ----------------
   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      else
         n_pass++;
   endtask

   // One record per clock cycle of expected DUT outputs.
   typedef struct packed {
      logic              busy;
      logic              done;
      logic              re;
      logic              we;
      logic              mis;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       wdata;
      logic [31:0]       rdata;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] model_rdata = 32'h0;

   task automatic push(input logic b, input logic d, input logic r, input logic w, input logic m,
                       input logic [ADDR_W-1:0] a, input logic [31:0] wd, input logic [31:0] rd);
      exp_t e;
      e.busy = b; e.done = d; e.re = r; e.we = w; e.mis = m;
      e.addr = a; e.wdata = wd; e.rdata = rd;
      exp_q.push_back(e);
   endtask

   // Builds the whole expected timeline of the request the DUT takes at the next edge.
   task automatic build();
      logic [1:0]        lane;
      logic [ADDR_W-1:0] wa;
      logic [31:0]       w;
      logic [31:0]       nv;
      logic [7:0]        b;
      logic [15:0]       h;
      logic              mis;
      lane = addr[1:0];
      wa   = addr[ADDR_W+1:2];
      w    = mem[wa];
      mis  = ((size == 2'b01) && addr[0]) || (size[1] && (lane != 2'b00));
      if (mis) begin
         push(1, 1, 0, 0, 1, wa, 0, model_rdata);
         push(0, 0, 0, 0, 0, wa, 0, model_rdata);
      end else if (we && size[1]) begin
         push(1, 0, 0, 1, 0, wa, wdata, model_rdata);
         push(1, 1, 0, 0, 0, wa, 0, model_rdata);
         push(0, 0, 0, 0, 0, wa, 0, model_rdata);
      end else if (!we) begin
         b = w[8*lane +: 8];
         h = w[16*lane[1] +: 16];
         if (size == 2'b00) begin
            nv = {24'h0, b};
            if (sext && b[7]) nv[31:8] = '1;
         end else if (size == 2'b01) begin
            nv = {16'h0, h};
            if (sext && h[15]) nv[31:16] = '1;
         end else begin
            nv = w;
         end
         push(1, 0, 1, 0, 0, wa, 0, model_rdata);
         push(1, 0, 0, 0, 0, wa, 0, model_rdata);
         push(1, 1, 0, 0, 0, wa, 0, nv);
         push(0, 0, 0, 0, 0, wa, 0, nv);
         model_rdata = nv;
      end else begin
         nv = w;
         if (size == 2'b00) nv[8*lane +: 8] = wdata[7:0];
         else               nv[16*lane[1] +: 16] = wdata[15:0];
         push(1, 0, 1, 0, 0, wa, 0, model_rdata);
         push(1, 0, 0, 0, 0, wa, 0, model_rdata);
         push(1, 0, 0, 1, 0, wa, nv, model_rdata);
         push(1, 1, 0, 0, 0, wa, 0, model_rdata);
         push(0, 0, 0, 0, 0, wa, 0, model_rdata);
      end
   endtask

   // Inputs settle at posedge+1, so at the negedge they equal what the next edge samples.
   always @(negedge clk) begin
      exp_t e;
      if (!rstn) begin
         exp_q.delete();
         model_rdata = 32'h0;
      end else begin
         if (exp_q.size() > 0) e = exp_q.pop_front();
         else e = '{busy: 1'b0, done: 1'b0, re: 1'b0, we: 1'b0, mis: 1'b0,
                    addr: '0, wdata: 32'h0, rdata: model_rdata};
         check("cyc_busy", busy, e.busy);
         check("cyc_done", done, e.done);
         check("cyc_mem_re", mem_re, e.re);
         check("cyc_mem_we", mem_we, e.we);
         check("cyc_misalign", misalign, e.mis);
         check("cyc_rdata", rdata, e.rdata);
         if (e.busy) check("cyc_mem_addr", 32'(mem_addr), 32'(e.addr));
         if (e.we)   check("cyc_mem_wdata", mem_wdata, e.wdata);
         if (exp_q.size() == 0 && req) build();
      end
   end

   // ---------------- driver tasks ----------------
   task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
      pre_addr = a; pre_data = d; pre_we = 1'b1;
      @(posedge clk); #1;
      pre_we = 1'b0;
   endtask

   task automatic do_req(input logic w, input logic [1:0] s, input logic se,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat, output int re_c, output int we_c,
                         output logic [31:0] wd, output logic [31:0] ma, output logic mis);
      we = w; size = s; sext = se; addr = a; wdata = d; req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0; addr = $urandom; wdata = $urandom; size = 2'($urandom_range(0, 3));
      lat = 0; re_c = 0; we_c = 0; wd = 32'h0; ma = 32'h0; mis = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (mem_re && re_c == 0) begin re_c = c; ma = 32'(mem_addr); end
         if (mem_we && we_c == 0) begin we_c = c; wd = mem_wdata; ma = 32'(mem_addr); end
         if (done) begin lat = c; mis = misalign; break; end
      end
      @(posedge clk); #1;
   endtask

   // ---------------- stimulus ----------------
   int          lat, re_c, we_c, nd, d1, d2;
   logic [31:0] wd, ma, r1, r2;
   logic        mis;

   logic [1:0]  ld_size [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
   logic        ld_sext [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
   logic [31:0] ld_addr [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
   logic [31:0] ld_exp  [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01};

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_misalign", misalign, 0);
      check("rst_mem_re", mem_re, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_rdata", rdata, 0);
      check("rst_mem_addr", 32'(mem_addr), 0);
      check("rst_mem_wdata", mem_wdata, 0);
      rstn = 1'b1;
      for (int i = 0; i < 8; i++) preload(ADDR_W'(i), $urandom);

      // word store
      do_req(1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, lat, re_c, we_c, wd, ma, mis);
      check("wst_latency", lat, 2);
      check("wst_we_cycle", we_c, 1);
      check("wst_re_cycle", re_c, 0);
      check("wst_mem_addr", ma, 4);
      check("wst_mem_wdata", wd, 32'hDEAD_BEEF);
      check("wst_misalign", mis, 0);
      check("wst_mem4", mem[4], 32'hDEAD_BEEF);

      // byte store, read-modify-write
      preload(4, 32'h1122_3344);
      do_req(1, 2'b00, 0, 32'h12, 32'h0000_00AA, lat, re_c, we_c, wd, ma, mis);
      check("bst_latency", lat, 4);
      check("bst_re_cycle", re_c, 1);
      check("bst_we_cycle", we_c, 3);
      check("bst_mem_wdata", wd, 32'h11AA_3344);
      check("bst_mem4", mem[4], 32'h11AA_3344);

      // loads with extension
      preload(4, 32'h80FF_7F01);
      for (int i = 0; i < 4; i++) begin
         do_req(0, ld_size[i], ld_sext[i], ld_addr[i], $urandom, lat, re_c, we_c, wd, ma, mis);
         check("ld_latency", lat, 3);
         check("ld_re_cycle", re_c, 1);
         check("ld_rdata", rdata, ld_exp[i]);
      end

      // misaligned halfword store and word load
      do_req(1, 2'b01, 0, 32'h11, 32'h0000_5555, lat, re_c, we_c, wd, ma, mis);
      check("mis_hst_latency", lat, 1);
      check("mis_hst_flag", mis, 1);
      check("mis_hst_access", re_c + we_c, 0);
      check("mis_hst_rdata", rdata, 32'h0000_7F01);
      check("mis_hst_mem4", mem[4], 32'h80FF_7F01);
      do_req(0, 2'b10, 0, 32'h12, 32'h0, lat, re_c, we_c, wd, ma, mis);
      check("mis_wld_latency", lat, 1);
      check("mis_wld_flag", mis, 1);
      check("mis_wld_access", re_c + we_c, 0);
      check("mis_wld_rdata", rdata, 32'h0000_7F01);

      // reset during WAIT of a byte store
      preload(4, 32'h1122_3344);
      we = 1'b1; size = 2'b00; sext = 1'b0; addr = 32'h12; wdata = 32'hAA; req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_mem_we", mem_we, 0);
      check("abort_mem_re", mem_re, 0);
      check("abort_done", done, 0);
      check("abort_rdata", rdata, 0);
      @(posedge clk); #1;
      rstn = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("abort_mem4", mem[4], 32'h1122_3344);
      do_req(0, 2'b10, 0, 32'h10, 32'h0, lat, re_c, we_c, wd, ma, mis);
      check("post_rst_latency", lat, 3);
      check("post_rst_rdata", rdata, 32'h1122_3344);

      // request held high across busy with a changing address
      preload(4, 32'h0BAD_F00D);
      preload(5, 32'h1234_8765);
      we = 1'b0; size = 2'b10; sext = 1'b0; addr = 32'h10; req = 1'b1;
      @(posedge clk); #1;
      nd = 0; d1 = 0; d2 = 0; r1 = 32'h0; r2 = 32'h0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (done) begin
            nd++;
            if (nd == 1) begin d1 = k; r1 = rdata; end
            else if (nd == 2) begin d2 = k; r2 = rdata; end
         end
         @(posedge clk); #1;
         if (k == 1) begin addr = 32'h14; size = 2'b01; sext = 1'b1; end
         if (k == 5) req = 1'b0;
      end
      check("hold_done_count", nd, 2);
      check("hold_first_cycle", d1, 3);
      check("hold_second_cycle", d2, 7);
      check("hold_first_rdata", r1, 32'h0BAD_F00D);
      check("hold_second_rdata", r2, 32'hFFFF_8765);

      // randomized traffic, including requests while busy and occasional resets
      for (int i = 0; i < 600; i++) begin
         req   = ($urandom_range(0, 1) == 1);
         we    = ($urandom_range(0, 1) == 1);
         size  = 2'($urandom_range(0, 3));
         sext  = ($urandom_range(0, 1) == 1);
         addr  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 31));
         wdata = $urandom;
         if ($urandom_range(0, 99) == 0) begin
            rstn = 1'b0;
            @(posedge clk); #1;
            rstn = 1'b1;
         end else begin
            @(posedge clk); #1;
         end
      end
      req = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("final_idle", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
